led_shift_driver: RTL

LED_SHIFT_DRIVER -- requirements
Module: led_shift_driver

---
 rtl/led_shift_driver.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/led_shift_driver.sv
// -----------------------------------------------------------------------------
// led_shift_driver
//
// Serialises a 32-bit LED pattern into an external shift-register chain
// (for example 74HC595 devices) and pulses the storage latch afterwards.
// A frame is sent whenever the pattern differs from the last one sent.
// A frame is also sent once after reset, so the chain always starts from
// a known state.
//
// Frame timing, with CLK_DIV clk_i cycles per sclk_o half-period:
//   32 x (SHIFT_LO + SHIFT_HI)  = 64*CLK_DIV cycles
//   LATCH                       =    CLK_DIV cycles
//   total with busy_o=1         = 65*CLK_DIV cycles
//
// Ports
//   clk_i    in   1   system clock, rising edge
//   rst_n_i  in   1   asynchronous active-low reset
//   leds_i   in  32   LED pattern, bit n = LED n on
//   sclk_o   out  1   shift clock; the chain samples sdo_o on its rising edge
//   sdo_o    out  1   serial data, bit 31 first
//   latch_o  out  1   storage latch strobe, active-high
//   busy_o   out  1   high while a frame is in progress
// -----------------------------------------------------------------------------
module led_shift_driver #(
  parameter int CLK_DIV = 4  // legal range 1..255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] leds_i,
  output logic        sclk_o,
  output logic        sdo_o,
  output logic        latch_o,
  output logic        busy_o
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q,   div_d;
  logic [4:0]  bit_q,   bit_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] sent_q,  sent_d;
  logic        init_q,  init_d;

  logic        sclk_d, sdo_d, latch_d, busy_d;

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave it
    // unassigned and no latch is inferred.
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sent_d  = sent_q;
    init_d  = init_q;

    unique case (state_q)
      IDLE: begin
        // leds_i is only looked at here, so a value that changes and then
        // reverts during a frame never causes another frame.
        if ((leds_i != sent_q) || init_q) begin
          shift_d = leds_i;
          sent_d  = leds_i;
          init_d  = 1'b0;
          bit_d   = 5'd31;
          div_d   = RELOAD;
          state_d = SHIFT_LO;
        end
      end

      SHIFT_LO: begin
        if (div_q == 8'd0) begin
          div_d   = RELOAD;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      SHIFT_HI: begin
        if (div_q == 8'd0) begin
          shift_d = {shift_q[30:0], 1'b0};
          div_d   = RELOAD;
          if (bit_q != 5'd0) begin
            bit_d   = bit_q - 5'd1;
            state_d = SHIFT_LO;
          end else begin
            state_d = LATCH;
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      LATCH: begin
        if (div_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // The outputs are decoded from the next state and then registered, so they
  // line up with the state register and have no combinational path to the
  // pins. The shift register moves only on the SHIFT_HI->SHIFT_LO edge. That
  // edge also drops sclk_o, so sdo_o never changes while sclk_o is high.
  always_comb begin
    sclk_d  = (state_d == SHIFT_HI);
    latch_d = (state_d == LATCH);
    busy_d  = (state_d != IDLE);
    sdo_d   = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? shift_d[31] : 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      bit_q   <= 5'd0;
      shift_q <= 32'd0;
      sent_q  <= 32'd0;
      init_q  <= 1'b1;
      sclk_o  <= 1'b0;
      sdo_o   <= 1'b0;
      latch_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sent_q  <= sent_d;
      init_q  <= init_d;
      sclk_o  <= sclk_d;
      sdo_o   <= sdo_d;
      latch_o <= latch_d;
      busy_o  <= busy_d;
    end
  end

endmodule
